// File: rtl/serial_multrom_table_pkg.sv
// Shared constants and state encoding for the self-filling multiplier lookup table.
package serial_multrom_table_pkg;
  localparam int DEF_HALF_WIDTH = 4;
  localparam int ADDR_W         = 2 * DEF_HALF_WIDTH;
  localparam int DEPTH          = 1 << ADDR_W;

  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } state_t;
endpackage

// File: rtl/multrom_table_ram.sv
// Product table storage: one synchronous write port, one asynchronous read port.
module multrom_table_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [AW-1:0] rdata
);
  logic [AW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/serial_multrom_table.sv
// Multiplier-ROM responder: builds the x*y table by repeated addition after reset,
// then serves zero-latency reads gated by ready.
module serial_multrom_table
  import serial_multrom_table_pkg::*;
#(
  parameter int HALF_WIDTH = DEF_HALF_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rebuild,
  input  logic [2*HALF_WIDTH-1:0] rom_address,
  output logic [2*HALF_WIDTH-1:0] rom_dout,
  output logic                    ready,
  output logic [2*HALF_WIDTH-1:0] fill_addr
);
  localparam int AW = 2 * HALF_WIDTH;

  state_t                state;
  logic [AW-1:0]         acc;
  logic [AW-1:0]         entry;
  logic [HALF_WIDTH-1:0] x_f, y_f;
  logic                  we;
  logic [AW-1:0]         rdata;

  assign x_f = fill_addr[AW-1:HALF_WIDTH];
  assign y_f = fill_addr[HALF_WIDTH-1:0];

  // Each row restarts at 0 when y wraps; (2^H-1)^2 fits in 2H bits, so no overflow.
  assign entry = (y_f == '0) ? '0 : acc + {{HALF_WIDTH{1'b0}}, x_f};

  // A rebuild edge writes nothing; the restarted fill rewrites address 0 next edge.
  assign we = (state == FILL) && !rebuild;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      ready     <= 1'b0;
      fill_addr <= '0;
      acc       <= '0;
    end else if (rebuild) begin
      state     <= FILL;
      ready     <= 1'b0;
      fill_addr <= '0;
      acc       <= '0;
    end else begin
      case (state)
        FILL: begin
          acc       <= entry;
          fill_addr <= fill_addr + 1'b1;
          if (fill_addr == '1) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY: begin
          state <= READY;
        end
        default: begin
          state <= FILL;
          ready <= 1'b0;
        end
      endcase
    end
  end

  multrom_table_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (fill_addr),
    .wdata (entry),
    .raddr (rom_address),
    .rdata (rdata)
  );

  // Gate on ready so stale memory or an undriven address never reaches the core.
  assign rom_dout = ready ? rdata : '0;
endmodule
